pe_tile_scheduler: RTL and testbench
====================================

Name: pe_tile_scheduler

Overview:
- Hardware tile scheduler for the multi-core matrix-multiply chip. It replaces bench-driven broadcast start with per-core dynamic dispatch.
- Hands num_tiles tile jobs to NUM_CORES processing elements, one job per idle core, via one-cycle pe_start pulses and a shared pe_instruction bus.
- Collects pe_done completions, counts tiles and cycles, and flags a stall through a progress watchdog.
- Sits between the host control registers and the PE array.

Parameters:
- NUM_CORES, 64, number of PEs served (1..64).
- TILE_W, 16, width of tile count/index.
- INSTR_W, 32, width of pe_instruction.
- CNT_W, 32, width of cycle counter.
- TIMEOUT_CYCLES, 1000000, cycles without any completion while any core busy before error.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle job launch; honoured only in IDLE or ERROR.
- abort  in  1  cancel current job.
- num_tiles  in  TILE_W  tiles in job; sampled on accepted start.
- base_instr  in  INSTR_W  instruction base; sampled on accepted start.
- pe_done  in  NUM_CORES  per-core done level from PEs.
- pe_start  out  NUM_CORES  one-hot one-cycle dispatch pulse.
- pe_instruction  out  INSTR_W  instruction for the core pulsed this cycle.
- busy  out  1  high in DISPATCH/DRAIN.
- done  out  1  one-cycle pulse on job completion.
- error  out  1  sticky watchdog error.
- tiles_done  out  TILE_W  completed tile count.
- cycle_count  out  CNT_W  cycles from accepted start to done; frozen afterwards.
- core_busy  out  NUM_CORES  per-core outstanding-tile mask.

Behaviour:
- Reset (async, rst=1): all outputs 0, state IDLE, internal next_tile=0, watchdog=0, pe_done history=0.
- FSM states: IDLE, DISPATCH, DRAIN, DONE, ERROR.
- IDLE/ERROR + start:
  - Latch num_tiles and base_instr.
  - Clear error, tiles_done, cycle_count and next_tile.
  - Go to DISPATCH, or to DONE if num_tiles==0.
- start in any other state is ignored.
- DISPATCH dispatch rule: each cycle, if next_tile<num_tiles and ~core_busy has any set bit:
  - Choose the lowest-index idle core c.
  - Register pe_start[c]=1 and pe_instruction=base_instr+next_tile (zero-extended, mod 2^INSTR_W).
  - Set core_busy[c] and increment next_tile.
- At most one dispatch per cycle. pe_start and pe_instruction are registered. pe_instruction holds its last value when no pulse is issued.
- Latency: start accepted on edge t gives the first pe_start high in cycle t+1.
- Completion: a rising edge of pe_done[k] with core_busy[k]=1 clears core_busy[k] and adds 1 to tiles_done.
  - Multiple completions in one cycle add their popcount.
  - A rising edge on a non-busy core is ignored.
  - Rising edge = pe_done & ~pe_done_q.
- Same-cycle completion and dispatch: idle selection uses the registered core_busy, so a core freed this cycle becomes eligible next cycle, never the same cycle.
- DISPATCH to DRAIN when next_tile==num_tiles after the dispatch.
- DRAIN to DONE when core_busy==0, including a clear in the same cycle.
- DONE: done=1 for exactly one cycle, then IDLE.
- cycle_count increments every cycle in DISPATCH/DRAIN and saturates at all-ones.
- Watchdog:
  - Counts cycles in DISPATCH/DRAIN where core_busy!=0 and no completion occurs.
  - Resets to 0 on any completion or accepted start.
  - Reaching TIMEOUT_CYCLES: state ERROR, error=1, pe_start=0. core_busy is kept for debug.
- ERROR: exited only by start (new job, core_busy cleared) or abort (to IDLE).
- abort in any non-IDLE state, with priority over all other events that cycle:
  - Next state IDLE, core_busy=0, pe_start=0, no done pulse.
  - tiles_done and cycle_count hold their values. error is cleared.
- Reset asserted mid-job returns to reset values immediately; in-flight PE work is not tracked.

Test Plan:
1. NUM_CORES=4, num_tiles=10, base_instr=0x100, each PE raises done 5 cycles after its start and drops it 1 cycle later -> pe_start order core0..3 on cycles 1..4, instructions 0x100..0x109 each exactly once, tiles_done=10, one done pulse, core_busy=0 at end.
2. num_tiles=0 with start -> done pulses the cycle after start, pe_start never asserted, tiles_done=0, cycle_count=0.
3. Core1 never completes, TIMEOUT_CYCLES=50 -> error=1 exactly 50 cycles after the last completion, core_busy[1]=1 retained, busy=0; subsequent start clears error.
4. Cores 0 and 2 raise pe_done in the same cycle -> tiles_done increases by 2 in one step; core0 is redispatched the next cycle (not the same cycle).
5. abort mid-DISPATCH after 3 dispatches -> IDLE next cycle, core_busy=0, no done pulse, tiles_done holds value; start during busy is ignored (num_tiles not relatched).
6. Spurious pe_done on an idle core and a held-high pe_done level -> no tiles_done change; only rising edges of busy cores count.

Source files
------------

// File: rtl/pe_tile_scheduler.sv
// Tile scheduler that hands out tile jobs one at a time to idle PEs.
// It picks the lowest-index idle core, tracks each core's outstanding tile,
// and counts completions. A progress watchdog moves the scheduler to ERROR
// when no tile completes for TIMEOUT_CYCLES cycles while cores are busy.
module pe_tile_scheduler #(
   parameter int NUM_CORES      = 64,
   parameter int TILE_W         = 16,
   parameter int INSTR_W        = 32,
   parameter int CNT_W          = 32,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 abort,
   input  logic [TILE_W-1:0]    num_tiles,
   input  logic [INSTR_W-1:0]   base_instr,
   input  logic [NUM_CORES-1:0] pe_done,
   output logic [NUM_CORES-1:0] pe_start,
   output logic [INSTR_W-1:0]   pe_instruction,
   output logic                 busy,
   output logic                 done,
   output logic                 error,
   output logic [TILE_W-1:0]    tiles_done,
   output logic [CNT_W-1:0]     cycle_count,
   output logic [NUM_CORES-1:0] core_busy
);

   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam int CI_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

   typedef enum logic [2:0] {S_IDLE, S_DISPATCH, S_DRAIN, S_DONE, S_ERROR} state_e;

   state_e               state_q, state_d;
   logic [TILE_W-1:0]    ntiles_q, ntiles_d;
   logic [INSTR_W-1:0]   base_q, base_d;
   logic [TILE_W-1:0]    next_q, next_d;
   logic [NUM_CORES-1:0] busy_q, busy_d;
   logic [TILE_W-1:0]    tiles_q, tiles_d;
   logic [CNT_W-1:0]     cyc_q, cyc_d;
   logic [WD_W-1:0]      wd_q, wd_d;
   logic                 err_q, err_d;
   logic [NUM_CORES-1:0] pstart_q, pstart_d;
   logic [INSTR_W-1:0]   instr_q, instr_d;
   logic [NUM_CORES-1:0] pdone_q;

   logic [NUM_CORES-1:0] comp;
   logic [TILE_W-1:0]    comp_cnt;
   logic                 idle_any;
   logic [CI_W-1:0]      idle_idx;
   logic                 running;

   // Completions (rising pe_done on a busy core) and lowest-index idle core.
   // Idle selection looks only at the registered busy mask, so a core freed
   // this cycle is not picked until the next one.
   always_comb begin
      comp     = pe_done & ~pdone_q & busy_q;
      comp_cnt = '0;
      idle_any = 1'b0;
      idle_idx = '0;
      for (int i = 0; i < NUM_CORES; i++)
         comp_cnt = comp_cnt + TILE_W'(comp[i]);
      for (int i = NUM_CORES - 1; i >= 0; i--) begin
         if (!busy_q[i]) begin
            idle_any = 1'b1;
            idle_idx = CI_W'(i);
         end
      end
   end

   // Next-state: abort beats everything, then start, then normal operation.
   always_comb begin
      state_d  = state_q;
      ntiles_d = ntiles_q;
      base_d   = base_q;
      next_d   = next_q;
      busy_d   = busy_q;
      tiles_d  = tiles_q;
      cyc_d    = cyc_q;
      wd_d     = wd_q;
      err_d    = err_q;
      pstart_d = '0;
      instr_d  = instr_q;
      running  = (state_q == S_DISPATCH) || (state_q == S_DRAIN);

      if (abort && state_q != S_IDLE) begin
         state_d = S_IDLE;
         busy_d  = '0;
         err_d   = 1'b0;
      end else if (start && (state_q == S_IDLE || state_q == S_ERROR)) begin
         ntiles_d = num_tiles;
         base_d   = base_instr;
         err_d    = 1'b0;
         tiles_d  = '0;
         cyc_d    = '0;
         wd_d     = '0;
         busy_d   = '0;
         next_d   = '0;
         if (num_tiles == '0) begin
            state_d = S_DONE;
         end else begin
            // First tile goes out on the accepting edge; every core is idle.
            pstart_d[0] = 1'b1;
            instr_d     = base_instr;
            busy_d[0]   = 1'b1;
            next_d      = TILE_W'(1);
            state_d     = (num_tiles == TILE_W'(1)) ? S_DRAIN : S_DISPATCH;
         end
      end else if (running) begin
         if (cyc_q != '1)
            cyc_d = cyc_q + CNT_W'(1);
         busy_d  = busy_q & ~comp;
         tiles_d = tiles_q + comp_cnt;
         if (comp != '0)
            wd_d = '0;
         else if (busy_q != '0)
            wd_d = wd_q + WD_W'(1);

         if (wd_d == WD_W'(TIMEOUT_CYCLES)) begin
            // Stall: stop dispatching, keep core_busy for post-mortem.
            state_d = S_ERROR;
            err_d   = 1'b1;
         end else if (state_q == S_DISPATCH) begin
            if (next_q < ntiles_q && idle_any) begin
               pstart_d[idle_idx] = 1'b1;
               instr_d            = base_q + INSTR_W'(next_q);
               busy_d[idle_idx]   = 1'b1;
               next_d             = next_q + TILE_W'(1);
               if (next_d == ntiles_q)
                  state_d = S_DRAIN;
            end
         end else if (busy_d == '0) begin
            state_d = S_DONE;
         end
      end else if (state_q == S_DONE) begin
         state_d = S_IDLE;
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         ntiles_q <= '0;
         base_q   <= '0;
         next_q   <= '0;
         busy_q   <= '0;
         tiles_q  <= '0;
         cyc_q    <= '0;
         wd_q     <= '0;
         err_q    <= 1'b0;
         pstart_q <= '0;
         instr_q  <= '0;
         pdone_q  <= '0;
      end else begin
         state_q  <= state_d;
         ntiles_q <= ntiles_d;
         base_q   <= base_d;
         next_q   <= next_d;
         busy_q   <= busy_d;
         tiles_q  <= tiles_d;
         cyc_q    <= cyc_d;
         wd_q     <= wd_d;
         err_q    <= err_d;
         pstart_q <= pstart_d;
         instr_q  <= instr_d;
         pdone_q  <= pe_done;
      end
   end

   assign pe_start       = pstart_q;
   assign pe_instruction = instr_q;
   assign busy           = (state_q == S_DISPATCH) || (state_q == S_DRAIN);
   assign done           = (state_q == S_DONE);
   assign error          = err_q;
   assign tiles_done     = tiles_q;
   assign cycle_count    = cyc_q;
   assign core_busy      = busy_q;

endmodule

// File: tb/tb_pe_tile_scheduler.sv
// Scoreboard bench for pe_tile_scheduler: a job-level reference model
// queues expected dispatches and done pulses; a monitor pops them on DUT
// pulses. A simple PE model answers dispatches with timed pe_done pulses.
module tb_pe_tile_scheduler;
   localparam int NC = 4, TW = 16, IW = 32, CW = 32, TO = 50;

   logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
   logic [TW-1:0] num_tiles = '0;
   logic [IW-1:0] base_instr = '0;
   logic [NC-1:0] pe_done = '0;
   logic [NC-1:0] pe_start, core_busy;
   logic [IW-1:0] pe_instruction;
   logic busy, done, error;
   logic [TW-1:0] tiles_done;
   logic [CW-1:0] cycle_count;

   pe_tile_scheduler #(.NUM_CORES(NC), .TILE_W(TW), .INSTR_W(IW), .CNT_W(CW),
                       .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .num_tiles(num_tiles),
      .base_instr(base_instr), .pe_done(pe_done), .pe_start(pe_start),
      .pe_instruction(pe_instruction), .busy(busy), .done(done), .error(error),
      .tiles_done(tiles_done), .cycle_count(cycle_count), .core_busy(core_busy));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0, errors = 0;
   task automatic chk(string name, longint act, longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
      end
   endtask

   typedef struct { int core; logic [IW-1:0] instr; int cyc; } disp_t;
   typedef struct { int tiles; int cyc; } done_t;
   disp_t dq[$];
   done_t fq[$];

   // ---------------- PE model ----------------
   logic [NC-1:0] pd_model = '0, spur = '0, hang_mask = '0, hold_mask = '0;
   int lat_cfg[NC];
   int sched[NC];
   initial begin
      for (int c = 0; c < NC; c++) begin lat_cfg[c] = 5; sched[c] = -1; end
      forever begin
         @(posedge clk); #3;
         for (int c = 0; c < NC; c++) begin
            if (pe_start[c] && !hang_mask[c])
               sched[c] = cyc + ((lat_cfg[c] > 0) ? lat_cfg[c] : int'($urandom_range(1, 8)));
            if (cyc == sched[c]) pd_model[c] = 1'b1;
            else if (!hold_mask[c]) pd_model[c] = 1'b0;
         end
         pe_done = pd_model | spur;
      end
   end

   // ---------------- reference model ----------------
   // ph: 0 idle, 1 running (dispatch/drain), 2 done, 3 error
   int ph = 0, m_n = 0, m_next = 0, m_tiles = 0, m_wd = 0;
   longint m_cyc = 0;
   logic [IW-1:0] m_base = '0;
   logic [NC-1:0] m_busy = '0, prev_done = '0;
   logic m_err = 1'b0;
   int max_step = 0, last_inc_cyc = 0, err_rise_cyc = 0;
   logic [TW-1:0] prev_tiles = '0;
   logic prev_err = 1'b0;
   initial begin
      logic [NC-1:0] rise, comp, nb;
      int c;
      forever begin
         @(posedge clk); #1;
         if (rst) begin
            prev_done = pe_done;
            continue;
         end
         rise = pe_done & ~prev_done;
         if (ph != 0 && abort) begin
            ph = 0; m_busy = '0; m_err = 1'b0;
         end else if ((ph == 0 || ph == 3) && start) begin
            m_n = int'(num_tiles); m_base = base_instr; m_err = 1'b0; m_tiles = 0;
            m_cyc = 0; m_wd = 0; m_busy = '0; m_next = 0;
            if (m_n == 0) ph = 2;
            else begin
               dq.push_back('{0, base_instr, cyc});
               m_busy = NC'(1); m_next = 1; ph = 1;
            end
         end else if (ph == 1) begin
            comp = rise & m_busy;
            if (m_cyc < 64'hFFFF_FFFF) m_cyc++;
            m_tiles += $countones(comp);
            if (comp != '0) m_wd = 0;
            else if (m_busy != '0) m_wd++;
            nb = m_busy & ~comp;
            if (m_wd == TO) begin
               ph = 3; m_err = 1'b1;
            end else if (m_next < m_n) begin
               if (m_busy != '1) begin
                  c = 0;
                  for (int i = NC - 1; i >= 0; i--) if (!m_busy[i]) c = i;
                  dq.push_back('{c, m_base + IW'(m_next), cyc});
                  nb[c] = 1'b1;
                  m_next++;
               end
            end else if (nb == '0) begin
               ph = 2;
            end
            m_busy = nb;
         end else if (ph == 2) begin
            ph = 0;
         end
         prev_done = pe_done;
         if (ph == 2) fq.push_back('{m_n, cyc});

         chk("core_busy", core_busy, m_busy);
         chk("tiles_done", tiles_done, m_tiles);
         chk("error", error, m_err);
         chk("busy", busy, ph == 1);
         chk("cycle_count", cycle_count, m_cyc);

         if (tiles_done > prev_tiles) begin
            if (int'(tiles_done - prev_tiles) > max_step) max_step = int'(tiles_done - prev_tiles);
            last_inc_cyc = cyc;
         end
         if (error && !prev_err) err_rise_cyc = cyc;
         prev_tiles = tiles_done;
         prev_err = error;
      end
   end

   // ---------------- monitor ----------------
   int pulses = 0, dones = 0;
   initial begin
      disp_t d;
      done_t f;
      forever begin
         @(negedge clk);
         if (rst) continue;
         if (pe_start != '0) begin
            pulses++;
            if (dq.size() == 0) chk("unexpected_pe_start", pe_start, 0);
            else begin
               d = dq.pop_front();
               chk("pe_start_core", pe_start, NC'(1) << d.core);
               chk("pe_instruction", pe_instruction, d.instr);
               chk("pe_start_cycle", cyc, d.cyc);
            end
         end else if (dq.size() > 0 && dq[0].cyc <= cyc) begin
            d = dq.pop_front();
            chk("missing_pe_start", 0, NC'(1) << d.core);
         end
         if (done) begin
            dones++;
            if (fq.size() == 0) chk("unexpected_done", done, 0);
            else begin
               f = fq.pop_front();
               chk("done_tiles", tiles_done, f.tiles);
               chk("done_cycle", cyc, f.cyc);
            end
         end else if (fq.size() > 0 && fq[0].cyc <= cyc) begin
            f = fq.pop_front();
            chk("missing_done", 0, 1);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick(int n = 1);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic launch(int n, logic [IW-1:0] b);
      start = 1'b1; num_tiles = TW'(n); base_instr = b;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(int budget, bit rnd_spur);
      bit seen = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (done) begin seen = 1'b1; break; end
         spur = '0;
         if (rnd_spur && $urandom_range(0, 5) == 0) spur = NC'($urandom) & ~core_busy;
         tick();
      end
      spur = '0;
      if (!seen) chk("wait_done_timeout", 0, 1);
      tick(2);
   endtask

   task automatic set_lat(int l);
      for (int c = 0; c < NC; c++) lat_cfg[c] = l;
   endtask

   initial begin
      int p0, d0;
      @(posedge clk); #1;
      chk("rst_pe_start", pe_start, 0);
      chk("rst_instr", pe_instruction, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_error", error, 0);
      chk("rst_tiles", tiles_done, 0);
      chk("rst_cycles", cycle_count, 0);
      chk("rst_core_busy", core_busy, 0);
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      tick(2);

      // 1: basic 10-tile job on 4 cores, fixed PE latency
      set_lat(5); p0 = pulses; d0 = dones;
      launch(10, 32'h100);
      wait_done(300, 1'b0);
      chk("t1_pulses", pulses - p0, 10);
      chk("t1_dones", dones - d0, 1);
      chk("t1_tiles", tiles_done, 10);
      chk("t1_core_busy", core_busy, 0);

      // 2: empty job
      p0 = pulses;
      launch(0, 32'h55);
      chk("t2_done_next_cycle", done, 1);
      tick(2);
      chk("t2_no_pulse", pulses - p0, 0);
      chk("t2_tiles", tiles_done, 0);
      chk("t2_cycles", cycle_count, 0);

      // 3: core1 hangs -> watchdog error; new start clears it
      hang_mask = 4'b0010;
      launch(6, 32'h200);
      for (int i = 0; i < 400 && !error; i++) tick();
      chk("t3_error", error, 1);
      chk("t3_wd_distance", err_rise_cyc - last_inc_cyc, TO);
      chk("t3_core1_kept", core_busy[1], 1);
      chk("t3_busy", busy, 0);
      hang_mask = '0;
      launch(2, 32'h300);
      chk("t3_error_cleared", error, 0);
      wait_done(300, 1'b0);

      // 4: cores 0 and 2 complete in the same cycle
      lat_cfg[0] = 5; lat_cfg[1] = 7; lat_cfg[2] = 3; lat_cfg[3] = 7;
      max_step = 0;
      launch(6, 32'h400);
      wait_done(300, 1'b0);
      chk("t4_step2", max_step, 2);
      chk("t4_tiles", tiles_done, 6);

      // 5: abort after 3 dispatches; start while busy is ignored
      set_lat(1); hang_mask = 4'b1110; p0 = pulses; d0 = dones;
      launch(10, 32'h500);
      start = 1'b1; num_tiles = TW'(2); base_instr = 32'h999;
      tick();
      start = 1'b0;
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("t5_busy", busy, 0);
      chk("t5_core_busy", core_busy, 0);
      tick(5);
      chk("t5_pulses", pulses - p0, 3);
      chk("t5_no_done", dones - d0, 0);
      chk("t5_tiles_held", tiles_done, 1);
      chk("t5_cycles_held", cycle_count, 2);
      hang_mask = '0;

      // 6: spurious and held-high pe_done
      spur = 4'b0101;
      tick(5);
      spur = 4'b0100;
      chk("t6_idle_spur", tiles_done, 1);
      set_lat(20);
      launch(3, 32'h600);
      tick(7);
      spur = 4'b1100;
      tick();
      spur = 4'b0100;
      tick(3);
      chk("t6_held_no_count", tiles_done, 0);
      tick(3);
      spur = '0;
      wait_done(300, 1'b0);
      chk("t6_tiles", tiles_done, 3);

      // 7: random jobs with random PE latency and spurious pulses
      set_lat(0);
      for (int j = 0; j < 6; j++) begin
         launch(int'($urandom_range(0, 24)), IW'($urandom));
         wait_done(2000, 1'b1);
      end

      tick(5);
      chk("dispatch_queue_empty", dq.size(), 0);
      chk("done_queue_empty", fq.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout cycle=%0d", cyc);
      $fatal(1);
   end
endmodule
